// File: rtl/dospi_frame.sv
// ============================================================================
//  Module   : dospi_frame
//  Purpose  : APA102-style SPI frame serializer (START / LED / END frames)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dospi_frame #(
   parameter int CLK_DIV     = 4,
   parameter int BRIGHTNESS  = 31,
   parameter int COLOR_CLAMP = 255,
   parameter int END_BITS    = 32
) (
   input  logic       dospi_frame_clk,
   input  logic       dospi_frame_reset_n,
   input  logic [7:0] blue_input,
   input  logic [7:0] green_input,
   input  logic [7:0] red_input,
   input  logic [1:0] type_input,
   input  logic       dospi_frame_start,
   output logic       dospi_frame_busy,
   output logic       dospi_frame_done,
   output logic       mosi,
   output logic       sck
);

   localparam int              DIV_W     = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [7:0]      CLAMP     = 8'(COLOR_CLAMP);
   localparam logic [4:0]      BRIGHT    = 5'(BRIGHTNESS);
   localparam logic [5:0]      END_LEN   = 6'(END_BITS);
   localparam logic [31:0]     END_FRAME = ~(32'hFFFF_FFFF >> END_BITS);

   localparam logic [1:0] TYPE_START = 2'd0;
   localparam logic [1:0] TYPE_LED   = 2'd1;
   localparam logic [1:0] TYPE_END   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOW    = 2'd1,
      ST_HIGH   = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       shift_q, shift_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;

   logic              accept;
   logic              div_end;
   logic [31:0]       load_frame;
   logic [5:0]        load_len;

   function automatic logic [7:0] clamp_chan(input logic [7:0] x);
      return (x > CLAMP) ? CLAMP : x;
   endfunction

   // A new request may be taken in the done cycle as well as in idle.
   assign accept  = ((state_q == ST_IDLE) || (state_q == ST_FINISH)) &&
                    dospi_frame_start && (type_input != 2'd3);
   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      load_frame = 32'h0000_0000;
      load_len   = 6'd32;
      case (type_input)
         TYPE_START: begin
            load_frame = 32'h0000_0000;
            load_len   = 6'd32;
         end
         TYPE_LED: begin
            load_frame = {3'b111, BRIGHT, clamp_chan(blue_input),
                          clamp_chan(green_input), clamp_chan(red_input)};
            load_len   = 6'd32;
         end
         TYPE_END: begin
            load_frame = END_FRAME;
            load_len   = END_LEN;
         end
         default: begin
            load_frame = 32'h0000_0000;
            load_len   = 6'd32;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      case (state_q)
         ST_IDLE, ST_FINISH: begin
            state_d = ST_IDLE;
            if (accept) begin
               shift_d = load_frame;
               cnt_d   = load_len;
               div_d   = '0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (div_end) begin
               div_d   = '0;
               state_d = ST_HIGH;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_HIGH: begin
            // The next bit appears on mosi only once sck has dropped again.
            if (div_end) begin
               div_d   = '0;
               shift_d = {shift_q[30:0], 1'b0};
               cnt_d   = cnt_q - 6'd1;
               state_d = (cnt_q == 6'd1) ? ST_FINISH : ST_LOW;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so the pins never glitch.
   always_comb begin
      busy_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
      done_d = (state_d == ST_FINISH);
      sck_d  = (state_d == ST_HIGH);
      mosi_d = busy_d & shift_d[31];
   end

   always_ff @(posedge dospi_frame_clk or negedge dospi_frame_reset_n) begin
      if (!dospi_frame_reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= 32'h0000_0000;
         cnt_q   <= 6'd0;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
      end
   end

   assign dospi_frame_busy = busy_q;
   assign dospi_frame_done = done_q;
   assign sck              = sck_q;
   assign mosi             = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_dospi_frame.sv
// ============================================================================
//  Module   : tb_dospi_frame
//  Purpose  : directed self-checking bench for dospi_frame
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dospi_frame;

   logic       clk;
   logic       rst_n;
   logic [7:0] blue, green, red;
   logic [1:0] type_in;
   logic       start;
   logic       busy, done, mosi, sck;

   int checks   = 0;
   int failures = 0;

   // Receiver model: sample mosi on every sck rising edge.
   logic [31:0] rx_data = 32'h0;
   int          rx_n    = 0;

   int          nb;
   bit          ok;
   int          base;
   bit          any_busy;

   dospi_frame #(
      .CLK_DIV    (2),
      .BRIGHTNESS (31),
      .COLOR_CLAMP(100),
      .END_BITS   (24)
   ) dut (
      .dospi_frame_clk    (clk),
      .dospi_frame_reset_n(rst_n),
      .blue_input         (blue),
      .green_input        (green),
      .red_input          (red),
      .type_input         (type_in),
      .dospi_frame_start  (start),
      .dospi_frame_busy   (busy),
      .dospi_frame_done   (done),
      .mosi               (mosi),
      .sck                (sck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge sck) begin
      rx_data = {rx_data[30:0], mosi};
      rx_n    = rx_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the request is accepted at the following posedge.
   task automatic pulse_start(input logic [1:0] t, input logic [7:0] b, g, r);
      type_in = t;
      blue    = b;
      green   = g;
      red     = r;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Counts busy cycles until done; optionally fires stray requests mid-frame.
   task automatic wait_done(input bit inject, output int nbusy, output bit seen);
      int c;
      nbusy = 0;
      seen  = 1'b0;
      c     = 1;
      for (int i = 0; i < 4000 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) nbusy++;
            if (inject && (c == 10 || c == 40)) begin
               start = 1'b1; type_in = 2'd1;
               blue = 8'h00; green = 8'h00; red = 8'h00;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; type_in = 2'd0;
      blue = 8'h00; green = 8'h00; red = 8'h00;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sck",  32'(sck),  32'd0);
      check("reset_mosi", 32'(mosi), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LED frame, colours below the clamp
      base = rx_n;
      pulse_start(2'd1, 8'h12, 8'h34, 8'h56);
      wait_done(1'b0, nb, ok);
      check("led_done_seen", 32'(ok), 32'd1);
      check("led_busy_len",  32'(nb), 32'd128);
      check("led_edges",     32'(rx_n - base), 32'd32);
      check("led_data",      rx_data, 32'hFF12_3456);
      @(negedge clk);
      check("led_done_pulse", 32'(done), 32'd0);
      check("led_idle_sck",   32'(sck),  32'd0);
      check("led_idle_mosi",  32'(mosi), 32'd0);

      // LED frame with clamping
      base = rx_n;
      pulse_start(2'd1, 8'd200, 8'd100, 8'd99);
      wait_done(1'b0, nb, ok);
      check("clamp_done_seen", 32'(ok), 32'd1);
      check("clamp_busy_len",  32'(nb), 32'd128);
      check("clamp_data",      rx_data, 32'hFF64_6463);
      @(negedge clk);

      // START then END back-to-back, END requested in the done cycle
      base = rx_n;
      pulse_start(2'd0, 8'hAA, 8'hBB, 8'hCC);
      wait_done(1'b0, nb, ok);
      check("start_done_seen", 32'(ok), 32'd1);
      check("start_busy_len",  32'(nb), 32'd128);
      check("start_data",      rx_data, 32'h0000_0000);
      check("start_gap_busy",  32'(busy), 32'd0);
      check("start_gap_sck",   32'(sck),  32'd0);
      pulse_start(2'd2, 8'h00, 8'h00, 8'h00);
      wait_done(1'b0, nb, ok);
      check("end_done_seen", 32'(ok), 32'd1);
      check("end_busy_len",  32'(nb), 32'd96);
      check("end_edges",     32'(rx_n - base), 32'd56);
      check("end_data",      rx_data, 32'h00FF_FFFF);
      @(negedge clk);

      // Stray requests and colour changes while busy
      base = rx_n;
      pulse_start(2'd1, 8'h21, 8'h43, 8'h65);
      wait_done(1'b1, nb, ok);
      check("ign_done_seen", 32'(ok), 32'd1);
      check("ign_busy_len",  32'(nb), 32'd128);
      check("ign_edges",     32'(rx_n - base), 32'd32);
      check("ign_data",      rx_data, 32'hFF21_4364);
      any_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         any_busy = any_busy | busy | done;
      end
      check("ign_not_queued", 32'(any_busy), 32'd0);

      // Reserved type is ignored
      base = rx_n;
      pulse_start(2'd3, 8'h12, 8'h34, 8'h56);
      any_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         any_busy = any_busy | busy | done;
         @(negedge clk);
      end
      check("rsv_no_activity", 32'(any_busy), 32'd0);
      check("rsv_no_edges",    32'(rx_n - base), 32'd0);

      // Asynchronous reset in the middle of bit 17
      base = rx_n;
      pulse_start(2'd1, 8'h12, 8'h34, 8'h56);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         if (rx_n - base >= 17) ok = 1'b1;
         else @(negedge clk);
      end
      check("rst_reach_bit17", 32'(ok), 32'd1);
      check("rst_pre_sck",     32'(sck), 32'd1);
      check("rst_partial",     {15'd0, rx_data[16:0]}, 32'h0001_FE24);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sck",  32'(sck),  32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      any_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         any_busy = any_busy | busy | done;
      end
      check("rst_no_resume", 32'(any_busy), 32'd0);
      base = rx_n;
      pulse_start(2'd0, 8'h00, 8'h00, 8'h00);
      wait_done(1'b0, nb, ok);
      check("post_done_seen", 32'(ok), 32'd1);
      check("post_busy_len",  32'(nb), 32'd128);
      check("post_edges",     32'(rx_n - base), 32'd32);
      check("post_data",      rx_data, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
